// File: rtl/mdu_pkg.sv
// Shared opcodes, FSM state type and opcode decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

   localparam logic [3:0] MDU_OP_MUL    = 4'd0;
   localparam logic [3:0] MDU_OP_MULH   = 4'd1;
   localparam logic [3:0] MDU_OP_MULHSU = 4'd2;
   localparam logic [3:0] MDU_OP_MULHU  = 4'd3;
   localparam logic [3:0] MDU_OP_DIV    = 4'd4;
   localparam logic [3:0] MDU_OP_DIVU   = 4'd5;
   localparam logic [3:0] MDU_OP_REM    = 4'd6;
   localparam logic [3:0] MDU_OP_REMU   = 4'd7;
   localparam logic [3:0] MDU_OP_MULW   = 4'd8;
   localparam logic [3:0] MDU_OP_DIVW   = 4'd12;
   localparam logic [3:0] MDU_OP_DIVUW  = 4'd13;
   localparam logic [3:0] MDU_OP_REMW   = 4'd14;
   localparam logic [3:0] MDU_OP_REMUW  = 4'd15;

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} mdu_state_t;

   function automatic logic is_div(input logic [3:0] op);
      return (op & 4'b0100) != 4'd0;
   endfunction

   function automatic logic is_word(input logic [3:0] op);
      return (op & 4'b1000) != 4'd0;
   endfunction

   // src1 is treated as signed for mulh, mulhsu and the signed divide/remainder ops
   function automatic logic is_signed(input logic [3:0] op);
      return (op[2:0] == 3'd1) || (op[2:0] == 3'd2) || (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder and try a subtract.
module mdu_div_step #(
   parameter int W = 64
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quot,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic [W-1:0] quot_next
);
   logic [W:0] shifted;
   logic [W:0] diff;

   // rem < divisor always holds, so diff[W] is a clean "subtract failed" flag
   assign shifted   = {rem, quot[W-1]};
   assign diff      = shifted - {1'b0, divisor};
   assign rem_next  = diff[W] ? shifted[W-1:0] : diff[W-1:0];
   assign quot_next = {quot[W-2:0], ~diff[W]};

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide, single-cycle special cases.
// Word ops (MULW/DIVW/DIVUW/REMW/REMUW) are built only when MDU_WORD_OPS_EN is defined.
import mdu_pkg::*;

module mdu_iter #(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_op,
   input  logic [XLEN-1:0] in_src1,
   input  logic [XLEN-1:0] in_src2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            busy,
   output mdu_state_t      dbg_state
);
   // Handshake: a request transfers on a rising edge with in_valid & in_ready & !flush;
   // a result transfers with out_valid & out_ready & !flush, and out_result holds until then.
   localparam int H  = XLEN / 2;
   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] ONES  = '1;
   localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(H+1){1'b1}}, {(H-1){1'b0}}};

   function automatic logic [XLEN-1:0] ext_half(input logic [H-1:0] v, input logic sgn);
      return {{H{sgn & v[H-1]}}, v};
   endfunction

   mdu_state_t state, state_next;
   logic              accept, word_in, word_q, legal, s1_sgn, s2_sgn, neg1, neg2, dz, ovf, fast;
   logic [XLEN-1:0]   opa, opb, absa, absb, fast_raw, fast_res;
   logic [CW-1:0]     n_iter, cnt;
   logic [3:0]        op_q;
   logic              neg_q, rsign_q;
   logic [2*XLEN-1:0] acc, mcand, prod;
   logic [XLEN-1:0]   mplier, rem, quot, dvsr, rem_step, quot_step;
   logic [XLEN-1:0]   q_fix, r_fix, fix_raw, fix_res;

   assign accept = in_valid && in_ready && !flush;
   assign s1_sgn = is_signed(in_op);
   assign s2_sgn = s1_sgn && (in_op != MDU_OP_MULHSU);

`ifdef MDU_WORD_OPS_EN
   assign word_in = is_word(in_op);
   assign word_q  = is_word(op_q);
   assign legal   = !word_in || (in_op == MDU_OP_MULW) || is_div(in_op);
   assign opa     = word_in ? ext_half(in_src1[H-1:0], s1_sgn) : in_src1;
   assign opb     = word_in ? ext_half(in_src2[H-1:0], s2_sgn) : in_src2;
`else
   assign word_in = 1'b0;
   assign word_q  = 1'b0;
   assign legal   = !is_word(in_op);
   assign opa     = in_src1;
   assign opb     = in_src2;
`endif

   assign neg1   = s1_sgn & opa[XLEN-1];
   assign neg2   = s2_sgn & opb[XLEN-1];
   assign absa   = neg1 ? -opa : opa;
   assign absb   = neg2 ? -opb : opb;
   assign n_iter = word_in ? CW'(H) : CW'(XLEN);
   assign dz     = is_div(in_op) && (opb == '0);
   assign ovf    = is_div(in_op) && s1_sgn && (opa == (word_in ? MIN_W : MIN_X)) && (opb == ONES);
   assign fast   = !legal || dz || ovf;

   always_comb begin
      fast_raw = '0;
      if (legal && dz)       fast_raw = in_op[1] ? opa : ONES;
      else if (legal && ovf) fast_raw = in_op[1] ? '0 : opa;
      fast_res = word_in ? ext_half(fast_raw[H-1:0], 1'b1) : fast_raw;
   end

   mdu_div_step #(.W(XLEN)) u_div_step (
      .rem       (rem),
      .quot      (quot),
      .divisor   (dvsr),
      .rem_next  (rem_step),
      .quot_next (quot_step)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:     if (in_valid) state_next = fast ? DONE : (is_div(in_op) ? DIV : MUL);
            MUL, DIV: if (cnt == CW'(1)) state_next = FIX;
            FIX:      state_next = DONE;
            DONE:     if (out_ready) state_next = IDLE;
            default:  state_next = IDLE;
         endcase
      end
   end

   // Sign fix-up and result selection, registered into out_result on the FIX cycle
   always_comb begin
      prod  = neg_q ? -acc : acc;
      q_fix = neg_q ? -quot : quot;
      r_fix = rsign_q ? -rem : rem;
      if (is_div(op_q))            fix_raw = op_q[1] ? r_fix : q_fix;
      else if (op_q[1:0] != 2'b00) fix_raw = prod[2*XLEN-1:XLEN];
      else                         fix_raw = prod[XLEN-1:0];
      fix_res = word_q ? ext_half(fix_raw[H-1:0], 1'b1) : fix_raw;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_q       <= '0;
         neg_q      <= 1'b0;
         rsign_q    <= 1'b0;
         cnt        <= '0;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         rem        <= '0;
         quot       <= '0;
         dvsr       <= '0;
         out_result <= '0;
      end else if (accept) begin
         op_q    <= in_op;
         neg_q   <= neg1 ^ neg2;
         rsign_q <= neg1;
         cnt     <= n_iter;
         acc     <= '0;
         mcand   <= {{XLEN{1'b0}}, absa};
         mplier  <= absb;
         rem     <= '0;
         // word dividends are left-aligned so the divide step always consumes from the MSB
         quot    <= word_in ? (absa << H) : absa;
         dvsr    <= absb;
         if (fast) out_result <= fast_res;
      end else if (state == MUL) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - 1'b1;
      end else if (state == DIV) begin
         rem  <= rem_step;
         quot <= quot_step;
         cnt  <= cnt - 1'b1;
      end else if (state == FIX) begin
         out_result <= fix_res;
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign dbg_state = state;

endmodule
